// File: rtl/reg_alu_processor.sv
// reg_alu_processor: multicycle register-file processor core.
// Accepts one {op_code, rd, rs_1, rs_2} instruction per valid/ready handshake,
// reads both operands, executes (MUL via an iterative shift-add loop), then
// writes rd and pulses o_done.
// Ports:
//   i_clock, i_reset             clock, synchronous active-high reset
//   i_instr_valid/o_instr_ready  instruction handshake (ready only in idle)
//   i_instruction                {op_code, rd, rs_1, rs_2}, MSB first
//   o_done, o_error              one-cycle completion / illegal-opcode pulses
//   o_result                     result of the last legal completed instruction
//   i_dbg_we/addr/wdata          debug register write (idle only)
//   o_dbg_rdata                  combinational register read at i_dbg_addr
module reg_alu_processor #(
  parameter int unsigned REGISTER_SIZE  = 32,
  parameter int unsigned REGISTER_COUNT = 1024,
  parameter int unsigned OPCODE_W       = 4,
  localparam int unsigned ADDR_W        = $clog2(REGISTER_COUNT),
  localparam int unsigned INSTR_W       = OPCODE_W + 3 * ADDR_W
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_instr_valid,
  output logic                     o_instr_ready,
  input  logic [INSTR_W-1:0]       i_instruction,
  output logic                     o_done,
  output logic [REGISTER_SIZE-1:0] o_result,
  output logic                     o_error,
  input  logic                     i_dbg_we,
  input  logic [ADDR_W-1:0]        i_dbg_addr,
  input  logic [REGISTER_SIZE-1:0] i_dbg_wdata,
  output logic [REGISTER_SIZE-1:0] o_dbg_rdata
);

  localparam int unsigned ShamtW = $clog2(REGISTER_SIZE);

  localparam logic [OPCODE_W-1:0] OpNop = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OpAdd = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OpMul = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OpAnd = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OpOr  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OpShl = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OpShr = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OpSub = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OpXor = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OpSra = OPCODE_W'(9);

  typedef enum logic [2:0] {StIdle, StRead, StExecute, StMulIter, StStore} state_e;

  state_e                   state_q;
  logic [OPCODE_W-1:0]      op_q;
  logic [ADDR_W-1:0]        rd_q, rs1_q, rs2_q;
  logic [REGISTER_SIZE-1:0] src1_q, src2_q;
  logic [REGISTER_SIZE-1:0] acc_q;      // ALU result or MUL accumulator
  logic [REGISTER_SIZE-1:0] mcand_q, mplier_q;
  logic [ShamtW-1:0]        cnt_q;
  logic [REGISTER_SIZE-1:0] result_q;
  logic                     done_q, error_q;

  logic [REGISTER_SIZE-1:0] regs [REGISTER_COUNT];

  logic [OPCODE_W-1:0]      in_op;
  logic [ADDR_W-1:0]        in_rd, in_rs1, in_rs2;
  logic [ShamtW-1:0]        shamt;
  logic [REGISTER_SIZE-1:0] alu_out;
  logic                     illegal;

  assign in_op  = i_instruction[INSTR_W-1 -: OPCODE_W];
  assign in_rd  = i_instruction[3*ADDR_W-1 -: ADDR_W];
  assign in_rs1 = i_instruction[2*ADDR_W-1 -: ADDR_W];
  assign in_rs2 = i_instruction[ADDR_W-1:0];

  assign shamt   = src2_q[ShamtW-1:0];
  assign illegal = (op_q > OpSra);

  assign o_instr_ready = (state_q == StIdle) && !i_reset;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_result      = result_q;
  assign o_dbg_rdata   = regs[i_dbg_addr];

  always_comb begin
    alu_out = '0;
    case (op_q)
      OpAdd:   alu_out = src1_q + src2_q;
      OpAnd:   alu_out = src1_q & src2_q;
      OpOr:    alu_out = src1_q | src2_q;
      OpShl:   alu_out = src1_q << shamt;
      OpShr:   alu_out = src1_q >> shamt;
      OpSub:   alu_out = src1_q - src2_q;
      OpXor:   alu_out = src1_q ^ src2_q;
      OpSra:   alu_out = $signed(src1_q) >>> shamt;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= StIdle;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_instr_valid) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
            // An all-zero instruction also has op_code NOP, so one test covers both.
            if (in_op != OpNop) state_q <= StRead;
          end
        end
        StRead: begin
          src1_q  <= regs[rs1_q];
          src2_q  <= regs[rs2_q];
          state_q <= StExecute;
        end
        StExecute: begin
          if (op_q == OpMul) begin
            acc_q    <= '0;
            mcand_q  <= src1_q;
            mplier_q <= src2_q;
            cnt_q    <= '0;
            state_q  <= StMulIter;
          end else begin
            acc_q   <= alu_out;
            state_q <= StStore;
          end
        end
        StMulIter: begin
          // Only the low half of the product is kept, so the shifted
          // multiplicand may simply drop its upper bits.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + ShamtW'(1);
          if (cnt_q == ShamtW'(REGISTER_SIZE - 1)) state_q <= StStore;
        end
        StStore: begin
          done_q  <= 1'b1;
          error_q <= illegal;
          if (!illegal) result_q <= acc_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Register file is not reset; store and debug writes are mutually exclusive by state.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if (state_q == StStore && !illegal) begin
        regs[rd_q] <= acc_q;
      end else if (state_q == StIdle && i_dbg_we) begin
        regs[i_dbg_addr] <= i_dbg_wdata;
      end
    end
  end

endmodule

// File: tb/tb_reg_alu_processor.sv
// tb_reg_alu_processor: directed and model-checked bench for reg_alu_processor.
module tb_reg_alu_processor;
  localparam int RS = 32;
  localparam int RC = 1024;
  localparam int OW = 4;
  localparam int AW = 10;
  localparam int IW = OW + 3 * AW;

  logic          clock = 1'b0;
  logic          reset, valid, ready, done, error, dbg_we;
  logic [IW-1:0] instr;
  logic [RS-1:0] result, dbg_wdata, dbg_rdata;
  logic [AW-1:0] dbg_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  reg_alu_processor #(
    .REGISTER_SIZE (RS),
    .REGISTER_COUNT(RC),
    .OPCODE_W      (OW)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_instr_valid(valid),
    .o_instr_ready(ready),
    .i_instruction(instr),
    .o_done       (done),
    .o_result     (result),
    .o_error      (error),
    .i_dbg_we     (dbg_we),
    .i_dbg_addr   (dbg_addr),
    .i_dbg_wdata  (dbg_wdata),
    .o_dbg_rdata  (dbg_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int a, input int b);
    return {OW'(op), AW'(rd), AW'(a), AW'(b)};
  endfunction

  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      1: r = a + b;
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a << b[4:0];
      6: r = a >> b[4:0];
      7: r = a - b;
      8: r = a ^ b;
      9: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic dbg_write(input int a, input logic [31:0] d);
    dbg_addr  = AW'(a);
    dbg_wdata = d;
    dbg_we    = 1'b1;
    tick();
    dbg_we = 1'b0;
  endtask

  task automatic dbg_read(input int a, output logic [31:0] d);
    dbg_addr = AW'(a);
    #1;
    d = dbg_rdata;
  endtask

  // Offers one instruction, drops valid, returns edges from acceptance to o_done (-1 on timeout).
  task automatic issue(input int op, input int rd, input int a, input int b, output int lat);
    instr = enc(op, rd, a, b);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    instr = '1;
    lat   = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] rd_val;
    logic [31:0] m [32];
    int          accepted, completed, outstanding, cyc;
    logic [31:0] exp_res;

    reset = 1'b1; valid = 1'b0; instr = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick();
    tick();
    check("reset_ready_in_reset", 32'(ready), 32'd0);
    reset = 1'b0;
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_ready", 32'(ready), 32'd1);

    // ADD
    dbg_write(1, 32'h5);
    dbg_write(2, 32'h3);
    issue(1, 10, 1, 2, lat);
    check("add_latency", 32'(lat), 32'd3);
    check("add_result", result, 32'h8);
    check("add_error", 32'(error), 32'd0);
    dbg_read(10, rd_val);
    check("add_r10", rd_val, 32'h8);

    // One op at a time on r3=all-ones, r4=2
    dbg_write(3, 32'hFFFF_FFFF);
    dbg_write(4, 32'h2);
    issue(2, 11, 3, 4, lat);
    check("mul_latency", 32'(lat), 32'd35);
    check("mul_result", result, 32'hFFFF_FFFE);
    issue(7, 12, 3, 4, lat);
    check("sub_result", result, 32'hFFFF_FFFD);
    issue(9, 13, 3, 4, lat);
    check("sra_result", result, 32'hFFFF_FFFF);
    issue(6, 14, 3, 4, lat);
    check("shr_result", result, 32'h3FFF_FFFF);
    issue(5, 15, 4, 3, lat);
    check("shl_result", result, 32'h0);
    issue(3, 16, 3, 4, lat);
    check("and_result", result, 32'h2);
    issue(4, 17, 4, 2, lat);
    check("or_result", result, 32'h3);
    issue(8, 18, 3, 4, lat);
    check("xor_result", result, 32'hFFFF_FFFD);
    dbg_read(11, rd_val);
    check("mul_r11", rd_val, 32'hFFFF_FFFE);
    dbg_read(15, rd_val);
    check("shl_r15", rd_val, 32'h0);

    // Same-register operands and back-to-back issue while o_done is high
    dbg_write(7, 32'h4);
    issue(1, 7, 7, 7, lat);
    check("same_add_result", result, 32'h8);
    check("b2b_ready_with_done", 32'({ready, done}), 32'b11);
    issue(2, 7, 7, 7, lat);
    check("b2b_mul_latency", 32'(lat), 32'd35);
    dbg_read(7, rd_val);
    check("b2b_mul_r7", rd_val, 32'h40);

    // NOP held valid
    dbg_write(0, 32'hA5A5_0000);
    instr = '0;
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nop_ready", 32'(ready), 32'd1);
      check("nop_done", 32'(done), 32'd0);
    end
    valid = 1'b0;
    dbg_read(0, rd_val);
    check("nop_r0", rd_val, 32'hA5A5_0000);
    dbg_read(7, rd_val);
    check("nop_r7", rd_val, 32'h40);

    // Illegal opcode
    dbg_write(5, 32'h55);
    issue(12, 5, 1, 2, lat);
    check("illegal_latency", 32'(lat), 32'd3);
    check("illegal_error", 32'(error), 32'd1);
    check("illegal_result", result, 32'h40);
    dbg_read(5, rd_val);
    check("illegal_rd", rd_val, 32'h55);
    tick();
    check("illegal_error_pulse", 32'({done, error}), 32'b00);

    // Reset in the middle of a MUL
    dbg_write(20, 32'h1234);
    instr = enc(2, 20, 1, 2);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midreset_ready", 32'(ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    check("midreset_no_done", 32'(pulses), 32'd0);
    dbg_read(20, rd_val);
    check("midreset_r20", rd_val, 32'h1234);
    issue(1, 21, 1, 2, lat);
    check("postreset_add_latency", 32'(lat), 32'd3);
    check("postreset_add_result", result, 32'h8);

    // Valid held high with a new random instruction every cycle
    for (int i = 0; i < 32; i++) begin
      m[i] = $urandom;
      dbg_write(i, m[i]);
    end
    accepted = 0; completed = 0; outstanding = 0; cyc = 0; exp_res = '0;
    while (completed < 200 && cyc < 20000) begin
      if (accepted < 200) begin
        int op, rd, a, b;
        op = $urandom_range(1, 9);
        rd = $urandom_range(0, 31);
        a  = $urandom_range(0, 31);
        b  = $urandom_range(0, 31);
        instr = enc(op, rd, a, b);
        valid = 1'b1;
        if (ready) begin
          check("rand_single_outstanding", 32'(outstanding), 32'd0);
          exp_res = model(op, m[a], m[b]);
          m[rd] = exp_res;
          outstanding = 1;
          accepted++;
        end
      end else begin
        valid = 1'b0;
      end
      tick();
      cyc++;
      if (done) begin
        check("rand_done_expected", 32'(outstanding), 32'd1);
        check("rand_result", result, exp_res);
        outstanding = 0;
        completed++;
      end
    end
    valid = 1'b0;
    check("rand_completed", 32'(completed), 32'd200);
    tick();
    for (int i = 0; i < 32; i++) begin
      dbg_read(i, rd_val);
      check("rand_regfile", rd_val, m[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_alu_processor.md
Name: reg_alu_processor

Overview:
- Parametrised multicycle register-file processor core: accepts one three-register instruction per valid/ready handshake and executes it against an internal register file.
- Adds SUB, XOR and SRA, an iterative shift-add multiplier, an illegal-opcode flag, a done/result strobe and a debug read/write port for preload and checking.
- Sits below the instruction source (bench or fetch unit) and replaces hierarchical peeking of register contents with ports.

Parameters:
- REGISTER_SIZE, 32, data width in bits; power of two, >= 8.
- REGISTER_COUNT, 1024, number of registers; power of two, >= 2. ADDR_W = clog2(REGISTER_COUNT).
- OPCODE_W, 4, opcode width. Instruction width = OPCODE_W + 3*ADDR_W.

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  synchronous, active-high.
- i_instr_valid  in  1  instruction offered.
- o_instr_ready  out  1  core can accept an instruction; high only in IDLE.
- i_instruction  in  OPCODE_W+3*ADDR_W  {op_code, rd, rs_1, rs_2}, MSB first.
- o_done  out  1  one-cycle pulse, asserted the cycle after a STORE edge.
- o_result  out  REGISTER_SIZE  value computed by the last completed instruction; held until next o_done.
- o_error  out  1  one-cycle pulse, coincident with o_done, for an illegal opcode.
- i_dbg_we  in  1  debug write enable.
- i_dbg_addr  in  ADDR_W  debug read/write address.
- i_dbg_wdata  in  REGISTER_SIZE  debug write data.
- o_dbg_rdata  out  REGISTER_SIZE  combinational read of registers[i_dbg_addr].

Behaviour:
- Opcodes:
  - 0 NOP, 1 ADD, 2 MUL, 3 AND, 4 OR, 5 SHL, 6 SHR, 7 SUB, 8 XOR, 9 SRA.
  - 10-15 are illegal.
- Arithmetic:
  - All results are truncated to REGISTER_SIZE bits.
  - MUL keeps the low half of the product.
  - SUB is rs_1 - rs_2, modulo 2^REGISTER_SIZE.
  - Shift amount is rs_2[clog2(REGISTER_SIZE)-1:0]. SHL and SHR are logical; SRA is arithmetic.
- States: IDLE, READ, EXECUTE, MUL_ITER, STORE.
  - IDLE:
    - o_instr_ready=1. On an edge with i_instr_valid=1, the instruction is latched.
    - If the instruction is all-zero or op_code=NOP: stay in IDLE, no write, no o_done.
    - Otherwise go to READ.
  - READ: latch src1=registers[rs_1] and src2=registers[rs_2]; go to EXECUTE.
  - EXECUTE:
    - MUL: clear the accumulator, load the multiplier, go to MUL_ITER.
    - Any other opcode: latch the result, go to STORE.
  - MUL_ITER:
    - Exactly REGISTER_SIZE edges, one multiplier bit per edge, LSB first.
    - After the last iteration, go to STORE.
  - STORE:
    - Write registers[rd] with the result; for an illegal opcode, suppress the write.
    - Update o_result (unchanged for an illegal opcode).
    - Assert o_done (and o_error if illegal) for the next cycle only; go to IDLE.
- Latency:
  - Counting edges from acceptance edge E0, the register write happens at E3, and o_done is high between E3 and E4.
  - MUL writes at E(3+REGISTER_SIZE).
  - A new instruction can be accepted at E4, while o_done is high.
- Hazards:
  - rd may equal rs_1 and/or rs_2; operands are latched in READ, so the old values are used.
  - A back-to-back instruction reading the prior rd sees the new value.
- Debug port:
  - i_dbg_we is honoured only in IDLE with i_reset=0, and has no effect on handshake state.
  - If a debug write and an instruction acceptance coincide, both take effect; the instruction's later READ sees the debug-written value.
  - o_dbg_rdata reflects writes from the next cycle onward.
- Reset (synchronous, active-high):
  - Reset values: state=IDLE, o_instr_ready=1 (from the cycle after reset), o_done=0, o_error=0, o_result=0. Multiplier counter and accumulator are cleared.
  - Reset during READ/EXECUTE/MUL_ITER/STORE abandons the instruction; no register is written on the reset edge.
  - Register-file contents are not reset.
- o_instr_ready is combinational from state (high iff IDLE and not in reset).
- i_instruction is sampled only on the acceptance edge; later changes are ignored.

Test Plan:
- Preload via debug: r1=0x0000_0005, r2=0x0000_0003. Issue ADD rd=10 rs_1=1 rs_2=2 -> o_done at E3+, o_result=0x8, dbg read r10=0x8, o_error=0.
- Preload r3=0xFFFF_FFFF, r4=0x0000_0002. Run each op in turn:
  - MUL rd=11 -> 0xFFFF_FFFE, o_done exactly 35 edges after acceptance.
  - SUB rd=12 -> 0xFFFF_FFFD.
  - SRA rd=13 -> 0xFFFF_FFFF.
  - SHR rd=14 -> 0x3FFF_FFFF.
  - SHL r4 by r3 (amount 31) -> 0x0000_0000.
- Same-register operands, r7=0x0000_0004: ADD rd=7 rs_1=7 rs_2=7 -> r7=0x8. Then issue MUL 7,7,7 immediately at E4 -> r7=0x40.
- NOP (all-zero instruction) held valid for 3 cycles -> ready stays high, no o_done, no register changes. Opcode 12 -> o_done and o_error pulse together at E3+, rd unchanged, o_result unchanged.
- Assert reset for one edge during MUL_ITER of MUL rd=20 (r20 preloaded 0x1234) -> r20 stays 0x1234, no o_done, ready=1 the next cycle, and the next ADD completes normally.
- i_instr_valid held high with a different instruction every cycle -> exactly one instruction accepted per IDLE visit, with each accepted instruction's result matching a software model over 200 random legal instructions.
